// File: rtl/ofifo.sv
// rtl/ofifo.sv - per-column output FIFOs that realign skewed MAC array psums into rows
module ofifo #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 64,
    parameter int addr_bw = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col*psum_bw-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [col*psum_bw-1:0] out,
    output logic                   o_valid,
    output logic                   o_ready,
    output logic                   o_full,
    output logic                   o_overflow
);

    logic [col-1:0]         empty;
    logic [col-1:0]         full;
    logic [col-1:0]         wr_ok;
    logic [col-1:0]         drop;
    logic [col*psum_bw-1:0] head;
    logic                   pop;

    assign o_ready = &(~empty);
    assign o_full  = |full;
    assign pop     = rd & o_ready;

    for (genvar c = 0; c < col; c++) begin : g_col
        logic [addr_bw:0]   wptr;
        logic [addr_bw:0]   rptr;
        logic [psum_bw-1:0] mem [depth];

        assign empty[c] = (wptr == rptr);
        assign full[c]  = (wptr[addr_bw-1:0] == rptr[addr_bw-1:0]) &&
                          (wptr[addr_bw] != rptr[addr_bw]);
        // A full column still accepts a write when the row pop frees its head slot this cycle.
        assign wr_ok[c] = wr[c] & (~full[c] | pop);
        assign drop[c]  = wr[c] & full[c] & ~pop;
        assign head[psum_bw*c +: psum_bw] = mem[rptr[addr_bw-1:0]];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (wr_ok[c]) wptr <= wptr + 1'b1;
                if (pop)      rptr <= rptr + 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (wr_ok[c]) mem[wptr[addr_bw-1:0]] <= in[psum_bw*c +: psum_bw];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out        <= '0;
            o_valid    <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            o_valid <= pop;
            if (pop)   out        <= head;
            if (|drop) o_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ofifo.sv
// tb/tb_ofifo.sv - directed self-checking bench for ofifo
module tb_ofifo;
    logic         clk;
    logic         reset;
    logic [127:0] in;
    logic [7:0]   wr;
    logic         rd;
    logic [127:0] out;
    logic         o_valid;
    logic         o_ready;
    logic         o_full;
    logic         o_overflow;

    int total = 0;
    int bad   = 0;

    ofifo dut (
        .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd),
        .out(out), .o_valid(o_valid), .o_ready(o_ready),
        .o_full(o_full), .o_overflow(o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] lanes(input logic [15:0] v0, input logic [15:0] step);
        logic [127:0] r;
        for (int c = 0; c < 8; c++) r[16*c +: 16] = v0 + step * 16'(c);
        return r;
    endfunction

    function automatic logic [127:0] same(input logic [15:0] v);
        return lanes(v, 16'd0);
    endfunction

    function automatic logic [127:0] row(input int i);
        return lanes(16'(i * 8), 16'd1);
    endfunction

    initial begin
        int pop_idx;
        logic [127:0] held;

        reset = 1'b0; in = '0; wr = '0; rd = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        check("rst_ready", o_ready, 0);
        check("rst_full", o_full, 0);
        check("rst_ovf", o_overflow, 0);
        check("rst_valid", o_valid, 0);
        check("rst_out", out, 0);

        // single row
        in = lanes(16'd1, 16'd1); wr = 8'hFF;
        tick();
        wr = '0;
        check("single_ready", o_ready, 1);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        check("single_valid", o_valid, 1);
        check("single_out", out, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        check("single_empty", o_ready, 0);
        tick();
        check("single_valid_pulse", o_valid, 0);

        // skewed columns
        for (int c = 0; c < 8; c++) begin
            in = same(16'h100 + 16'(c)); wr = 8'(1 << c);
            tick();
            check($sformatf("skew_ready%0d", c), o_ready, (c == 7) ? 1 : 0);
        end
        wr = '0; rd = 1'b1;
        tick();
        rd = 1'b0;
        check("skew_valid", o_valid, 1);
        check("skew_out", out, lanes(16'h100, 16'd1));

        // read ignored while column 3 is empty
        in = same(16'h55); wr = 8'hF7;
        tick();
        wr = '0;
        held = out;
        check("ign_ready", o_ready, 0);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        check("ign_valid", o_valid, 0);
        check("ign_out", out, held);
        in = same(16'h55); wr = 8'h08;
        tick();
        wr = '0; rd = 1'b1;
        tick();
        rd = 1'b0;
        check("ign_drain", out, same(16'h55));

        // full plus simultaneous pop
        for (int r = 0; r < 64; r++) begin
            in = row(r); wr = 8'hFF;
            tick();
        end
        wr = '0;
        check("fp_full", o_full, 1);
        in = same(16'h0BEE); wr = 8'hFF; rd = 1'b1;
        tick();
        wr = '0;
        check("fp_ovf", o_overflow, 0);
        check("fp_first", out, row(0));
        check("fp_still_full", o_full, 1);
        for (int r = 1; r < 64; r++) begin
            tick();
            check($sformatf("fp_pop%0d", r), out, row(r));
        end
        tick();
        rd = 1'b0;
        check("fp_bee", out, same(16'h0BEE));
        check("fp_drained", o_ready, 0);

        // full / overflow on column 0
        for (int r = 0; r < 64; r++) begin
            in = same(16'(r)); wr = 8'h01;
            tick();
        end
        check("ovf_full", o_full, 1);
        check("ovf_pre", o_overflow, 0);
        in = same(16'hDEAD); wr = 8'h01;
        tick();
        check("ovf_set", o_overflow, 1);
        for (int r = 0; r < 64; r++) begin
            in = same(16'(r)); wr = 8'hFE;
            tick();
        end
        wr = '0; rd = 1'b1;
        for (int r = 0; r < 64; r++) begin
            tick();
            check($sformatf("ovf_pop%0d", r), out, same(16'(r)));
        end
        rd = 1'b0;
        check("ovf_drained", o_ready, 0);
        check("ovf_sticky", o_overflow, 1);

        // wrap-around streaming
        pop_idx = 0;
        for (int i = 0; i < 260 && pop_idx < 200; i++) begin
            wr = (i < 200) ? 8'hFF : 8'h00;
            in = row(i);
            rd = o_ready;
            tick();
            if (o_valid) begin
                check($sformatf("wrap%0d", pop_idx), out, row(pop_idx));
                pop_idx++;
            end
        end
        wr = '0; rd = 1'b0;
        check("wrap_count", 128'(pop_idx), 128'd200);
        check("wrap_empty", o_ready, 0);

        // asynchronous reset mid-stream
        for (int r = 0; r < 5; r++) begin
            in = row(r); wr = 8'hFF;
            tick();
        end
        wr = '0;
        check("ar_ready_pre", o_ready, 1);
        #2 reset = 1'b0;
        #1;
        check("ar_ready", o_ready, 0);
        check("ar_full", o_full, 0);
        check("ar_ovf", o_overflow, 0);
        check("ar_out", out, 0);
        tick();
        reset = 1'b1;
        rd = 1'b1;
        tick();
        check("ar_no_pop", o_valid, 0);
        rd = 1'b0; in = same(16'h0ABC); wr = 8'hFF;
        tick();
        wr = '0; rd = 1'b1;
        tick();
        rd = 1'b0;
        check("ar_new_valid", o_valid, 1);
        check("ar_new_out", out, same(16'h0ABC));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
